// File: rtl/spi_txn_arbiter_if.sv
// Requester-side handshake and spi_master-side signals of the SPI transaction arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface spi_txn_arbiter_if;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic        spi_start;
    logic [1:0]  spi_slave_select;
    logic [7:0]  spi_data_in;
    logic        spi_done_flag;
    logic [7:0]  spi_recieved_data;

    modport slave (
        input  req, wdata, spi_done_flag, spi_recieved_data,
        output ack, rvalid, rdata, err, busy, spi_start, spi_slave_select, spi_data_in
    );

    modport master (
        output req, wdata, spi_done_flag, spi_recieved_data,
        input  ack, rvalid, rdata, err, busy, spi_start, spi_slave_select, spi_data_in
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_master between four requesters,
// with a per-transfer timeout and an idle gap between transactions.
module spi_txn_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 2
) (
    input  logic             clk,
    input  logic             reset,
    spi_txn_arbiter_if.slave bus
);

    // state     | meaning
    // S_IDLE    | waiting for any req, grant captured on exit
    // S_START   | ack visible, spi_start issued on exit
    // S_WAIT    | counting cycles until done_flag or timeout
    // S_RESP    | rvalid visible for the granted requester
    // S_GAP     | idle spacing before the next arbitration
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t      r_state;
    logic [1:0]  r_last_grant;
    logic [1:0]  r_gnt_id;
    logic [15:0] r_timer;
    logic [15:0] r_gap;
    logic [3:0]  r_ack;
    logic [3:0]  r_rvalid;
    logic [7:0]  r_rdata;
    logic        r_err;
    logic        r_busy;
    logic        r_spi_start;
    logic [1:0]  r_sel;
    logic [7:0]  r_din;

    logic [1:0]  w_winner;
    logic [1:0]  w_idx;
    logic        w_found;
    logic [7:0]  w_wbyte;

    // Scan starts one past the last served requester, so nobody repeats while others wait.
    always_comb begin
        w_winner = r_last_grant;
        w_idx    = r_last_grant;
        w_found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_wbyte = bus.wdata[{w_winner, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'd3;
            r_gnt_id     <= 2'd0;
            r_timer      <= 16'd0;
            r_gap        <= 16'd0;
            r_ack        <= 4'd0;
            r_rvalid     <= 4'd0;
            r_rdata      <= 8'd0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_spi_start  <= 1'b0;
            r_sel        <= 2'd0;
            r_din        <= 8'd0;
        end else begin
            r_ack       <= 4'd0;
            r_rvalid    <= 4'd0;
            r_spi_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_din    <= w_wbyte;
                        r_sel    <= w_winner;
                        r_gnt_id <= w_winner;
                        r_ack    <= 4'b0001 << w_winner;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_spi_start <= 1'b1;
                    r_timer     <= 16'd0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 16'd1;
                    // done_flag takes precedence over a timeout landing on the same cycle
                    if (bus.spi_done_flag) begin
                        r_rdata  <= bus.spi_recieved_data;
                        r_err    <= 1'b0;
                        r_rvalid <= 4'b0001 << r_gnt_id;
                        r_state  <= S_RESP;
                    end else if (r_timer == TIMER_LAST) begin
                        r_rdata  <= 8'h00;
                        r_err    <= 1'b1;
                        r_rvalid <= 4'b0001 << r_gnt_id;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_gnt_id;
                    if (GAP_CYCLES == 0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap   <= GAP_LAST;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == 16'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack              = r_ack;
    assign bus.rvalid           = r_rvalid;
    assign bus.rdata            = r_rdata;
    assign bus.err              = r_err;
    assign bus.busy             = r_busy;
    assign bus.spi_start        = r_spi_start;
    assign bus.spi_slave_select = r_sel;
    assign bus.spi_data_in      = r_din;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed, table-driven bench for spi_txn_arbiter with a simple spi_master response model.
// Built with TIMEOUT_CYCLES=16 and GAP_CYCLES=2.
module tb_spi_txn_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_txn_arbiter_if bus ();

    spi_txn_arbiter #(
        .TIMEOUT_CYCLES(16),
        .GAP_CYCLES    (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [7:0]  mbyte;
        int          mdelay;
        logic [1:0]  id;
        logic [7:0]  rdata;
        bit          err;
        bit          drop;
    } vec_t;

    vec_t vecs[9];

    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_delay  = -1;
    logic [7:0] m_byte   = 8'h00;
    bit         mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // spi_master model: done_flag m_delay cycles after spi_start is seen; negative never answers
    initial begin
        bus.spi_done_flag     = 1'b0;
        bus.spi_recieved_data = 8'h5A;
        forever begin
            @(negedge clk);
            if (bus.spi_start === 1'b1 && m_delay >= 0) begin
                repeat (m_delay) @(negedge clk);
                bus.spi_done_flag     = 1'b1;
                bus.spi_recieved_data = m_byte;
                @(negedge clk);
                bus.spi_done_flag     = 1'b0;
                bus.spi_recieved_data = 8'h5A;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en)
                chk("ack_rvalid_onehot",
                    32'(($countones(bus.ack) + $countones(bus.rvalid)) <= 1), 32'd1);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"},       32'(bus.ack), 32'h0);
        chk({tag, "_rvalid"},    32'(bus.rvalid), 32'h0);
        chk({tag, "_rdata"},     32'(bus.rdata), 32'h0);
        chk({tag, "_err"},       32'(bus.err), 32'h0);
        chk({tag, "_busy"},      32'(bus.busy), 32'h0);
        chk({tag, "_spi_start"}, 32'(bus.spi_start), 32'h0);
        chk({tag, "_sel"},       32'(bus.spi_slave_select), 32'h0);
        chk({tag, "_din"},       32'(bus.spi_data_in), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'd0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        reset = 1'b1;
    endtask

    // Called at a negedge; v.rst means the FSM is known to sit in IDLE right now.
    task automatic txn(input vec_t v);
        bit   seen;
        int   n;
        int   exp_lat;
        logic [7:0] exp_din;
        exp_din = 8'(v.wdata >> (8 * int'(v.id)));
        exp_lat = (v.mdelay < 0 || v.mdelay > 15) ? 16 : v.mdelay + 1;
        bus.req   = v.req;
        bus.wdata = v.wdata;
        m_byte    = v.mbyte;
        m_delay   = v.mdelay;

        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (bus.ack !== 4'd0) seen = 1'b1;
        end
        chk("ack_seen", 32'(seen), 32'd1);
        chk("ack_latency", 32'(n), v.rst ? 32'd1 : 32'd4);
        chk("ack_id", 32'(bus.ack), 32'(4'b0001 << v.id));
        chk("busy_start", 32'(bus.busy), 32'd1);
        if (v.drop) bus.req = 4'd0;

        @(negedge clk);
        chk("spi_start", 32'(bus.spi_start), 32'd1);
        chk("spi_sel", 32'(bus.spi_slave_select), 32'(v.id));
        chk("spi_din", 32'(bus.spi_data_in), 32'(exp_din));
        chk("ack_pulse", 32'(bus.ack), 32'd0);

        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("spi_start_pulse", 32'(bus.spi_start), 32'd0);
            if (bus.rvalid !== 4'd0) seen = 1'b1;
        end
        chk("rvalid_seen", 32'(seen), 32'd1);
        chk("rvalid_latency", 32'(n), 32'(exp_lat));
        chk("rvalid_id", 32'(bus.rvalid), 32'(4'b0001 << v.id));
        chk("rdata", 32'(bus.rdata), 32'(v.rdata));
        chk("err", 32'(bus.err), 32'(v.err));
        chk("busy_resp", 32'(bus.busy), 32'd1);
        chk("sel_stable", 32'(bus.spi_slave_select), 32'(v.id));
    endtask

    initial begin
        int   n_rv;
        int   n_ack;
        int   n_st;
        bit   seen;
        vec_t va;

        reset     = 1'b0;
        bus.req   = 4'd0;
        bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        mon_en = 1'b1;
        reset  = 1'b1;

        //            rst req      wdata         mbyte  dly  id    rdata  err drop
        vecs[0] = '{1, 4'b0001, 32'h000000A5, 8'h3C, 3,   2'd0, 8'h3C, 0, 1};
        vecs[1] = '{1, 4'b1111, 32'h13121110, 8'h90, 2,   2'd0, 8'h90, 0, 0};
        vecs[2] = '{0, 4'b1111, 32'h13121110, 8'h91, 4,   2'd1, 8'h91, 0, 0};
        vecs[3] = '{0, 4'b1111, 32'h13121110, 8'h92, 1,   2'd2, 8'h92, 0, 0};
        vecs[4] = '{0, 4'b1111, 32'h13121110, 8'h93, 7,   2'd3, 8'h93, 0, 0};
        vecs[5] = '{0, 4'b1111, 32'h13121110, 8'h94, 5,   2'd0, 8'h94, 0, 0};
        vecs[6] = '{0, 4'b1010, 32'h2B2A2928, 8'h55, -1,  2'd1, 8'h00, 1, 0};
        vecs[7] = '{0, 4'b1010, 32'h3B3A3938, 8'h66, 15,  2'd3, 8'h66, 0, 0};
        vecs[8] = '{0, 4'b0110, 32'hC3C2C1C0, 8'h77, 6,   2'd1, 8'h77, 0, 1};

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            txn(vecs[i]);
        end

        // Reset in the middle of a hung transfer for requester 3
        bus.req   = 4'b1000;
        bus.wdata = 32'hD3000000;
        m_delay   = -1;
        seen      = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.ack !== 4'd0) seen = 1'b1;
        end
        chk("abort_ack", 32'(bus.ack), 32'b1000);
        bus.req = 4'd0;
        repeat (6) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        chk("abort_sel_before", 32'(bus.spi_slave_select), 32'd3);
        reset = 1'b0;
        @(negedge clk);
        chk_reset("mid");
        n_rv = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rvalid !== 4'd0) n_rv++;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.rvalid !== 4'd0) n_rv++;
        end
        chk("abort_no_rvalid", 32'(n_rv), 32'd0);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        va = '{1, 4'b0100, 32'h00B00000, 8'hC7, 4, 2'd2, 8'hC7, 0, 1};
        txn(va);

        // Request pulsed during GAP and withdrawn before IDLE must not be served
        va = '{0, 4'b0001, 32'h000000A1, 8'h3D, 2, 2'd0, 8'h3D, 0, 1};
        txn(va);
        @(negedge clk);
        bus.req   = 4'b0100;
        bus.wdata = 32'h00EE0000;
        @(negedge clk);
        bus.req = 4'd0;
        n_ack = 0;
        n_st  = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.ack !== 4'd0) n_ack++;
            if (bus.spi_start === 1'b1) n_st++;
        end
        chk("withdraw_no_ack", 32'(n_ack), 32'd0);
        chk("withdraw_no_start", 32'(n_st), 32'd0);
        chk("withdraw_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
